// File: rtl/rgb2y_ctrl.sv
// rgb2y_ctrl: raster timing and coefficient controller for the rgb2y converter.
//
// Walks an H_TOT x V_TOT raster while running, reads pixel memory for the
// H_ACT x V_ACT active window, and produces dv/hs/vs aligned to the one-cycle
// memory read latency. Coefficient writes are staged in shadow registers and
// only applied at a frame boundary (or at once when idle), so kr_o/kb_o never
// change within a frame.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run_i               level request to generate frames
//   cfg_wr_i            strobe capturing cfg_kr_i / cfg_kb_i into the shadow
//   rd_o, addr_o        pixel memory read enable and address (row*H_ACT+col)
//   dv_o, hs_o, vs_o    timing to rgb2y, one cycle behind rd_o/addr_o
//   kr_o, kb_o          applied coefficients
//   upd_o               one-cycle pulse when new coefficients take effect
//   busy_o              high while a frame is being generated or finishing
//   frame_cnt_o         completed frame count (only with RGB2Y_CTRL_FRAME_CNT_EN)
//
// Optional feature: define RGB2Y_CTRL_FRAME_CNT_EN to add frame_cnt_o.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | raster parked at col=row=0, no reads, coefficients apply at once
// RUN      | generating frames, run_i held high
// STOPPING | run_i dropped, finishing the current frame
module rgb2y_ctrl #(
   parameter int H_ACT  = 512,
   parameter int V_ACT  = 512,
   parameter int H_TOT  = 563,
   parameter int V_TOT  = 563,
   parameter int HS_BEG = 523,
   parameter int HS_END = 531,
   parameter int VS_BEG = 523,
   parameter int VS_END = 531,
   parameter int KR_DEF = 27865,
   parameter int KB_DEF = 9463,
   parameter int ADDR_W = 18
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run_i,
   input  logic                cfg_wr_i,
   input  logic signed [17:0]  cfg_kr_i,
   input  logic signed [17:0]  cfg_kb_i,
   output logic                rd_o,
   output logic [ADDR_W-1:0]   addr_o,
   output logic                dv_o,
   output logic                hs_o,
   output logic                vs_o,
   output logic signed [17:0]  kr_o,
   output logic signed [17:0]  kb_o,
   output logic                upd_o,
   output logic                busy_o
`ifdef RGB2Y_CTRL_FRAME_CNT_EN
   ,
   output logic [15:0]         frame_cnt_o
`endif
);

   localparam int CW = (H_TOT > 1) ? $clog2(H_TOT) : 1;
   localparam int RW = (V_TOT > 1) ? $clog2(V_TOT) : 1;

   localparam logic [CW-1:0] H_LAST_C = CW'(H_TOT - 1);
   localparam logic [RW-1:0] V_LAST_C = RW'(V_TOT - 1);
   localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
   localparam logic [RW-1:0] V_ACT_C  = RW'(V_ACT);
   localparam logic [CW-1:0] HS_BEG_C = CW'(HS_BEG);
   localparam logic [CW-1:0] HS_END_C = CW'(HS_END);
   localparam logic [RW-1:0] VS_BEG_C = RW'(VS_BEG);
   localparam logic [RW-1:0] VS_END_C = RW'(VS_END);
   localparam logic signed [17:0] KR_DEF_C = 18'(KR_DEF);
   localparam logic signed [17:0] KB_DEF_C = 18'(KB_DEF);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOPPING
   } state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         col, col_nxt;
   logic [RW-1:0]         row, row_nxt;
   logic                  active;
   logic                  frame_end;
   logic                  pix_vis;
   logic                  apply;
   logic                  pending;
   logic signed [17:0]    kr_sh, kb_sh;

   assign active    = (state != ST_IDLE);
   assign frame_end = (col == H_LAST_C) && (row == V_LAST_C);
   assign pix_vis   = active && (col < H_ACT_C) && (row < V_ACT_C);
   assign apply     = !active || frame_end;

   assign rd_o   = pix_vis;
   assign addr_o = pix_vis ? (ADDR_W'(row) * ADDR_W'(H_ACT) + ADDR_W'(col)) : '0;
   assign busy_o = active;

   // Dropping run_i on the frame-end cycle itself goes straight to IDLE:
   // the frame is already complete and no further frame must be started.
   always_comb begin
      state_nxt = state;
      col_nxt   = '0;
      row_nxt   = '0;
      case (state)
         ST_IDLE:     if (run_i) state_nxt = ST_RUN;
         ST_RUN:      if (!run_i) state_nxt = frame_end ? ST_IDLE : ST_STOPPING;
         ST_STOPPING: begin
            if (run_i)          state_nxt = ST_RUN;
            else if (frame_end) state_nxt = ST_IDLE;
         end
         default:     state_nxt = ST_IDLE;
      endcase
      if (active && !frame_end) begin
         if (col == H_LAST_C) begin
            col_nxt = '0;
            row_nxt = row + RW'(1);
         end else begin
            col_nxt = col + CW'(1);
            row_nxt = row;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         col     <= '0;
         row     <= '0;
         dv_o    <= 1'b0;
         hs_o    <= 1'b0;
         vs_o    <= 1'b0;
         upd_o   <= 1'b0;
         kr_o    <= KR_DEF_C;
         kb_o    <= KB_DEF_C;
         kr_sh   <= KR_DEF_C;
         kb_sh   <= KB_DEF_C;
         pending <= 1'b0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
         dv_o  <= pix_vis;
         hs_o  <= active && (col >= HS_BEG_C) && (col <= HS_END_C);
         vs_o  <= active && (row >= VS_BEG_C) && (row <= VS_END_C);
         upd_o <= apply && pending;
         if (apply && pending) begin
            kr_o <= kr_sh;
            kb_o <= kb_sh;
         end
         // A write on the apply cycle wins: the old shadow goes out, the new
         // value stays pending for the next apply point.
         if (cfg_wr_i) begin
            kr_sh   <= cfg_kr_i;
            kb_sh   <= cfg_kb_i;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
      end
   end

`ifdef RGB2Y_CTRL_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)                    frame_cnt_o <= '0;
      else if (active && frame_end) frame_cnt_o <= frame_cnt_o + 16'd1;
   end
`endif

endmodule

// File: tb/tb_rgb2y_ctrl.sv
module tb_rgb2y_ctrl;

   localparam int H_ACT  = 8;
   localparam int V_ACT  = 6;
   localparam int H_TOT  = 12;
   localparam int V_TOT  = 10;
   localparam int HS_BEG = 9;
   localparam int HS_END = 10;
   localparam int VS_BEG = 7;
   localparam int VS_END = 8;
   localparam int KR_DEF = 27865;
   localparam int KB_DEF = 9463;
   localparam int ADDR_W = 18;
   localparam int FRM    = H_TOT * V_TOT;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               run_i = 1'b0;
   logic               cfg_wr_i = 1'b0;
   logic signed [17:0] cfg_kr_i = '0;
   logic signed [17:0] cfg_kb_i = '0;
   logic               rd_o;
   logic [ADDR_W-1:0]  addr_o;
   logic               dv_o, hs_o, vs_o;
   logic signed [17:0] kr_o, kb_o;
   logic               upd_o, busy_o;
`ifdef RGB2Y_CTRL_FRAME_CNT_EN
   logic [15:0]        frame_cnt_o;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rgb2y_ctrl #(
      .H_ACT(H_ACT), .V_ACT(V_ACT), .H_TOT(H_TOT), .V_TOT(V_TOT),
      .HS_BEG(HS_BEG), .HS_END(HS_END), .VS_BEG(VS_BEG), .VS_END(VS_END),
      .KR_DEF(KR_DEF), .KB_DEF(KB_DEF), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .run_i(run_i), .cfg_wr_i(cfg_wr_i),
      .cfg_kr_i(cfg_kr_i), .cfg_kb_i(cfg_kb_i),
      .rd_o(rd_o), .addr_o(addr_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
      .kr_o(kr_o), .kb_o(kb_o), .upd_o(upd_o), .busy_o(busy_o)
`ifdef RGB2Y_CTRL_FRAME_CNT_EN
      , .frame_cnt_o(frame_cnt_o)
`endif
   );

   // Reference model: raster position as a linear cycle index within the frame.
   bit                 m_busy;
   int                 m_pos;
   bit                 m_pending;
   logic signed [17:0] m_skr, m_skb;
   logic signed [17:0] e_kr, e_kb;
   logic               e_dv, e_hs, e_vs, e_upd;
   logic [15:0]        e_fcnt;

   function automatic logic exp_rd();
      int c, r;
      c = m_pos % H_TOT;
      r = m_pos / H_TOT;
      return m_busy && c < H_ACT && r < V_ACT;
   endfunction

   function automatic logic [ADDR_W-1:0] exp_addr();
      int c, r;
      c = m_pos % H_TOT;
      r = m_pos / H_TOT;
      return exp_rd() ? ADDR_W'(r * H_ACT + c) : '0;
   endfunction

   task automatic model_step();
      int c, r;
      bit at_end, apply, was_busy;
      c = m_pos % H_TOT;
      r = m_pos / H_TOT;
      if (rst) begin
         m_busy = 0; m_pos = 0; m_pending = 0;
         e_dv = 0; e_hs = 0; e_vs = 0; e_upd = 0;
         e_kr = 18'(KR_DEF); e_kb = 18'(KB_DEF); e_fcnt = '0;
         return;
      end
      at_end   = m_busy && (m_pos == FRM - 1);
      was_busy = m_busy;
      e_dv  = exp_rd();
      e_hs  = m_busy && c >= HS_BEG && c <= HS_END;
      e_vs  = m_busy && r >= VS_BEG && r <= VS_END;
      apply = !m_busy || at_end;
      e_upd = apply && m_pending;
      if (e_upd) begin
         e_kr = m_skr; e_kb = m_skb; m_pending = 0;
      end
      if (cfg_wr_i) begin
         m_skr = cfg_kr_i; m_skb = cfg_kb_i; m_pending = 1;
      end
      if (at_end) e_fcnt = e_fcnt + 16'd1;
      if (!m_busy || at_end) m_busy = run_i;
      m_pos = (was_busy && !at_end) ? m_pos + 1 : 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic advance_to(input int target);
      int k;
      k = 0;
      while (!(m_busy && m_pos == target) && k < 2 * FRM) begin
         tick();
         k++;
      end
      if (k >= 2 * FRM) begin
         n_chk++; n_fail++;
         $display("FAIL advance_to: position %0d not reached, model at %0d", target, m_pos);
      end
   endtask

   task automatic test_reset();
      rst = 1; run_i = 0; cfg_wr_i = 0;
      tick(); tick();
      rst = 0;
      tick();
      n_chk++; if (kr_o !== 18'sd27865) begin n_fail++; $display("FAIL reset_kr: got %0d want 27865", kr_o); end
      n_chk++; if (kb_o !== 18'sd9463) begin n_fail++; $display("FAIL reset_kb: got %0d want 9463", kb_o); end
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_chk++; if ({rd_o, dv_o, hs_o, vs_o, upd_o} !== 5'b0) begin
         n_fail++; $display("FAIL reset_strobes: got %b want 00000", {rd_o, dv_o, hs_o, vs_o, upd_o});
      end
      n_chk++; if (addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", addr_o); end
   endtask

   task automatic test_frame();
      int n_dv, n_hs, last_addr;
      n_dv = 0; n_hs = 0; last_addr = -1;
      run_i = 1;
      tick();
      n_chk++; if (rd_o !== 1'b1 || addr_o !== '0 || dv_o !== 1'b0) begin
         n_fail++; $display("FAIL first_read: rd=%b addr=%0d dv=%b want rd=1 addr=0 dv=0", rd_o, addr_o, dv_o);
      end
      tick();
      n_chk++; if (dv_o !== 1'b1) begin n_fail++; $display("FAIL first_dv: got %b want 1", dv_o); end
      n_dv++;
      for (int i = 0; i < 2 * FRM - 1; i++) begin
         if (rd_o) last_addr = int'(addr_o);
         tick();
         if (dv_o) n_dv++;
         if (hs_o) n_hs++;
         n_chk++;
         if ({rd_o, addr_o, dv_o, hs_o, vs_o, busy_o} !== {exp_rd(), exp_addr(), e_dv, e_hs, e_vs, 1'b1}) begin
            n_fail++;
            $display("FAIL frame_timing pos=%0d: rd=%b addr=%0d dv=%b hs=%b vs=%b busy=%b want %b %0d %b %b %b 1",
                     m_pos, rd_o, addr_o, dv_o, hs_o, vs_o, busy_o, exp_rd(), exp_addr(), e_dv, e_hs, e_vs);
         end
      end
      n_chk++; if (n_dv != 2 * H_ACT * V_ACT) begin n_fail++; $display("FAIL dv_count: got %0d want %0d", n_dv, 2 * H_ACT * V_ACT); end
      n_chk++; if (n_hs != 2 * V_TOT * (HS_END - HS_BEG + 1)) begin
         n_fail++; $display("FAIL hs_count: got %0d want %0d", n_hs, 2 * V_TOT * (HS_END - HS_BEG + 1));
      end
      n_chk++; if (last_addr != H_ACT * V_ACT - 1) begin n_fail++; $display("FAIL last_addr: got %0d want %0d", last_addr, H_ACT * V_ACT - 1); end
   endtask

   task automatic test_cfg_midframe();
      int n_upd, k;
      n_upd = 0;
      run_i = 1;
      advance_to(2 * H_TOT + 3);
      cfg_wr_i = 1; cfg_kr_i = 18'sd20000; cfg_kb_i = 18'sd5000;
      tick();
      cfg_wr_i = 0;
      k = 0;
      while (m_pos != 0 && k < 2 * FRM) begin
         n_chk++; if (kr_o !== 18'sd27865 || upd_o !== 1'b0) begin
            n_fail++; $display("FAIL cfg_hold pos=%0d: kr=%0d upd=%b want 27865 0", m_pos, kr_o, upd_o);
         end
         tick();
         k++;
         if (upd_o) n_upd++;
      end
      for (int i = 0; i < FRM / 2; i++) begin
         tick();
         if (upd_o) n_upd++;
      end
      n_chk++; if (kr_o !== 18'sd20000 || kb_o !== 18'sd5000) begin
         n_fail++; $display("FAIL cfg_applied: kr=%0d kb=%0d want 20000 5000", kr_o, kb_o);
      end
      n_chk++; if (n_upd != 1) begin n_fail++; $display("FAIL upd_pulses: got %0d want 1", n_upd); end
   endtask

   task automatic test_cfg_at_apply();
      run_i = 1;
      advance_to(FRM / 2);
      cfg_wr_i = 1; cfg_kr_i = 18'sd111; cfg_kb_i = 18'sd222;
      tick();
      cfg_wr_i = 0;
      advance_to(FRM - 1);
      cfg_wr_i = 1; cfg_kr_i = -18'sd333; cfg_kb_i = 18'sd444;
      tick();
      cfg_wr_i = 0;
      n_chk++; if (kr_o !== 18'sd111 || kb_o !== 18'sd222 || upd_o !== 1'b1) begin
         n_fail++; $display("FAIL apply_old_shadow: kr=%0d kb=%0d upd=%b want 111 222 1", kr_o, kb_o, upd_o);
      end
      advance_to(FRM - 1);
      n_chk++; if (kr_o !== 18'sd111) begin n_fail++; $display("FAIL pending_held: kr=%0d want 111", kr_o); end
      tick();
      n_chk++; if (kr_o !== -18'sd333 || kb_o !== 18'sd444 || upd_o !== 1'b1) begin
         n_fail++; $display("FAIL apply_new_shadow: kr=%0d kb=%0d upd=%b want -333 444 1", kr_o, kb_o, upd_o);
      end
   endtask

   task automatic test_stop();
      int k;
      run_i = 1;
      advance_to(3 * H_TOT);
      run_i = 0;
      k = 0;
      while (busy_o === 1'b1 && k < 2 * FRM) begin
         tick();
         k++;
      end
      n_chk++; if (k != FRM - 3 * H_TOT) begin n_fail++; $display("FAIL stop_latency: busy fell after %0d cycles want %0d", k, FRM - 3 * H_TOT); end
      n_chk++; if (m_busy !== 1'b0 || rd_o !== 1'b0) begin n_fail++; $display("FAIL stop_idle: rd=%b model_busy=%b want 0 0", rd_o, m_busy); end
      cfg_wr_i = 1; cfg_kr_i = -18'sd5; cfg_kb_i = 18'sd7;
      tick();
      cfg_wr_i = 0;
      tick();
      n_chk++; if (kr_o !== -18'sd5 || kb_o !== 18'sd7 || upd_o !== 1'b1) begin
         n_fail++; $display("FAIL idle_apply: kr=%0d kb=%0d upd=%b want -5 7 1", kr_o, kb_o, upd_o);
      end
   endtask

   task automatic test_reset_mid();
      int n_upd;
      n_upd = 0;
      run_i = 1;
      advance_to(H_TOT + 1);
      cfg_wr_i = 1; cfg_kr_i = 18'sd1234; cfg_kb_i = 18'sd4321;
      tick();
      cfg_wr_i = 0;
      advance_to(4 * H_TOT + 5);
      rst = 1; run_i = 0;
      tick();
      rst = 0;
      n_chk++; if (busy_o !== 1'b0 || dv_o !== 1'b0 || rd_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_idle: busy=%b dv=%b rd=%b want 0 0 0", busy_o, dv_o, rd_o);
      end
      n_chk++; if (kr_o !== 18'sd27865 || kb_o !== 18'sd9463) begin
         n_fail++; $display("FAIL rst_mid_coef: kr=%0d kb=%0d want 27865 9463", kr_o, kb_o);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (upd_o) n_upd++;
      end
      n_chk++; if (n_upd != 0 || kr_o !== 18'sd27865) begin
         n_fail++; $display("FAIL rst_mid_pending: upd pulses=%0d kr=%0d want 0 27865", n_upd, kr_o);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 4) run_i = ~run_i;
         cfg_wr_i = ($urandom_range(0, 29) == 0);
         cfg_kr_i = 18'($urandom);
         cfg_kb_i = 18'($urandom);
         rst      = ($urandom_range(0, 999) == 0);
         tick();
         n_chk++;
         if ({rd_o, addr_o, dv_o, hs_o, vs_o, busy_o, upd_o, kr_o, kb_o} !==
             {exp_rd(), exp_addr(), e_dv, e_hs, e_vs, logic'(m_busy), e_upd, e_kr, e_kb}) begin
            n_fail++;
            $display("FAIL random_cycle %0d: rd=%b addr=%0d dv=%b hs=%b vs=%b busy=%b upd=%b kr=%0d kb=%0d want %b %0d %b %b %b %b %b %0d %0d",
                     i, rd_o, addr_o, dv_o, hs_o, vs_o, busy_o, upd_o, kr_o, kb_o,
                     exp_rd(), exp_addr(), e_dv, e_hs, e_vs, m_busy, e_upd, e_kr, e_kb);
         end
`ifdef RGB2Y_CTRL_FRAME_CNT_EN
         n_chk++;
         if (frame_cnt_o !== e_fcnt) begin
            n_fail++; $display("FAIL frame_cnt cycle %0d: got %0d want %0d", i, frame_cnt_o, e_fcnt);
         end
`endif
      end
      rst = 0; cfg_wr_i = 0;
   endtask

   initial begin
      test_reset();
      test_frame();
      test_cfg_midframe();
      test_cfg_at_apply();
      test_stop();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb2y_ctrl.md
RGB2Y_CTRL -- requirements
Module: rgb2y_ctrl

Interface
REQ-001 Parameter H_ACT, 512, active pixels per line.
REQ-002 Parameter V_ACT, 512, active lines per frame.
REQ-003 Parameter H_TOT, 563, total columns per line (col 0..H_TOT-1).
REQ-004 Parameter V_TOT, 563, total rows per frame (row 0..V_TOT-1).
REQ-005 Parameters HS_BEG, 523, and HS_END, 531: inclusive column range of hsync.
REQ-006 Parameters VS_BEG, 523, and VS_END, 531: inclusive row range of vsync.
REQ-007 Parameters KR_DEF, 27865, and KB_DEF, 9463: reset coefficients.
REQ-008 Parameter ADDR_W, 18: pixel address width.
REQ-009 clk  in  1  single clock; all logic on rising edge.
REQ-010 rst  in  1  reset; synchronous, active-high.
REQ-011 run_i  in  1  level; request frames to be generated.
REQ-012 cfg_wr_i  in  1  one-cycle strobe; capture cfg_kr_i/cfg_kb_i.
REQ-013 cfg_kr_i, cfg_kb_i  in  18 each  signed new coefficients.
REQ-014 rd_o  out  1  pixel memory read enable.
REQ-015 addr_o  out  ADDR_W  pixel index row*H_ACT+col.
REQ-016 dv_o, hs_o, vs_o  out  1 each  timing to rgb2y inputs.
REQ-017 kr_o, kb_o  out  18 each  signed coefficients to rgb2y.
REQ-018 upd_o  out  1  one-cycle pulse when coefficients applied.
REQ-019 busy_o  out  1  high in RUN or STOPPING.

Function
REQ-020 FSM states IDLE, RUN, STOPPING; IDLE holds col=row=0, rd_o=dv_o=hs_o=vs_o=0.
REQ-021 IDLE->RUN when run_i=1; first RUN cycle has col=0,row=0.
REQ-022 RUN: col increments each cycle, wraps H_TOT-1->0; row increments on col wrap, wraps V_TOT-1->0.
REQ-023 RUN->STOPPING when run_i=0; STOPPING->RUN if run_i=1 before frame end; STOPPING->IDLE on cycle after col=H_TOT-1,row=V_TOT-1 (current frame always completes).
REQ-024 rd_o=1 and addr_o valid combinationally-registered for cycles with col<H_ACT and row<V_ACT; addr_o=0 otherwise.
REQ-025 dv_o, hs_o, vs_o lag rd_o/addr_o by exactly 1 cycle (memory read latency 1); dv_o is rd_o delayed.
REQ-026 hs_o=1 for col in [HS_BEG,HS_END]; vs_o=1 for row in [VS_BEG,VS_END]; both independent of dv.
REQ-027 cfg_wr_i loads shadow registers and sets pending; later writes before apply overwrite shadow.
REQ-028 Apply point: frame-end cycle (col=H_TOT-1,row=V_TOT-1) in RUN/STOPPING, or any cycle in IDLE; if pending, kr_o/kb_o <= shadow next cycle, upd_o pulses, pending clears.
REQ-029 cfg_wr_i coinciding with apply point: previous shadow applied; new value captured and left pending.
REQ-030 kr_o/kb_o never change mid-frame; widths unchanged, no arithmetic on coefficients.

Reset
REQ-031 rst while active: next cycle state=IDLE, col=row=0, all strobes 0, pending=0.
REQ-032 Reset values: kr_o=KR_DEF, kb_o=KB_DEF, addr_o=0, upd_o=0, busy_o=0, frame_cnt_o=0.
REQ-033 rst dominates run_i and cfg_wr_i in the same cycle.

Configuration
REQ-034 Macro RGB2Y_CTRL_FRAME_CNT_EN defined: port frame_cnt_o (16 bit) present, increments at each completed frame end, wraps 65535->0.
REQ-035 Macro undefined: frame_cnt_o port and counter absent; all other behaviour identical.

Verification
REQ-036 rst 2 cycles, run_i=0 -> kr_o=27865, kb_o=9463, busy_o=0, all strobes 0.
REQ-037 run_i=1 held -> rd_o first cycle addr_o=0; dv_o high 1 cycle later; 512 dv_o per line, 262144 per frame; last addr 262143.
REQ-038 Per line: hs_o high 9 cycles at col 523..531 (+1 latency); vs_o high rows 523..531; line period 563 cycles.
REQ-039 cfg_wr_i kr=20000,kb=5000 mid-frame -> kr_o unchanged until frame end, then 20000/5000 with one upd_o pulse.
REQ-040 run_i dropped at row 100 -> frame completes, busy_o falls after col=562,row=562; in IDLE a cfg write applies next cycle.
REQ-041 rst asserted mid-line at row 10 col 200 -> next cycle IDLE, dv_o=0, kr_o/kb_o back to defaults, pending cleared.
